// File: rtl/cpu_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_trace_buffer
// Brief    : 8-entry retirement trace FIFO for SingleCycleCPU. It records
//            {pc, instr, data, wb} per committed instruction, counts dropped
//            entries and stops capturing once a halt instruction retires.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_trace_buffer (
  input  logic        clk,
  input  logic        Reset,
  input  logic        enable,
  input  logic        clear,
  input  logic        PCWre,
  input  logic [31:0] PcOut,
  input  logic [31:0] instruction,
  input  logic        RegWre,
  input  logic [31:0] WriteData,
  input  logic        rd_ready,
  output logic        rd_valid,
  output logic [31:0] rd_pc,
  output logic [31:0] rd_instr,
  output logic [31:0] rd_data,
  output logic        rd_wb,
  output logic [3:0]  count,
  output logic        overflow,
  output logic [7:0]  drop_cnt,
  output logic        halted
);

  localparam logic [31:0] HALT_INSTR = 32'hFC00_0000;
  localparam int          DEPTH      = 8;
  localparam logic [3:0]  FULL_COUNT = 4'd8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HALTED  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [31:0]      data_mem  [DEPTH];
  logic [DEPTH-1:0] wb_mem;

  logic [2:0] rd_ptr;
  logic [2:0] wr_ptr;

  logic flush;
  logic push_req;
  logic pop;
  logic push_ok;
  logic push_drop;
  logic halt_seen;

  // Reset and clear are functionally identical; either one flushes everything.
  assign flush     = Reset | clear;
  // enable is re-checked here so that enable dropping on the commit edge
  // suppresses the push even though the state is still CAPTURE.
  assign push_req  = (state == CAPTURE) & enable & PCWre;
  assign pop       = rd_valid & rd_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok   = push_req & ((count != FULL_COUNT) | pop);
  assign push_drop = push_req & (count == FULL_COUNT) & ~pop;
  // Halt is recognised even if the halt entry itself gets dropped.
  assign halt_seen = push_req & (instruction == HALT_INSTR);

  assign rd_valid = (count != 4'd0);
  assign halted   = (state == HALTED);

  // Head entry comes straight from storage; forced to zero when empty so the
  // outputs read 0 after reset/clear regardless of stale storage contents.
  assign rd_pc    = rd_valid ? pc_mem[rd_ptr]    : 32'h0;
  assign rd_instr = rd_valid ? instr_mem[rd_ptr] : 32'h0;
  assign rd_data  = rd_valid ? data_mem[rd_ptr]  : 32'h0;
  assign rd_wb    = rd_valid & wb_mem[rd_ptr];

  // Next-state logic: capture follows enable until a halt retires.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (enable) state_nx = CAPTURE;
      end
      CAPTURE: begin
        if (!enable)        state_nx = IDLE;
        else if (halt_seen) state_nx = HALTED;
      end
      HALTED: begin
        state_nx = HALTED;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State register; HALTED is only left through a flush.
  always_ff @(posedge clk) begin
    if (flush) state <= IDLE;
    else       state <= state_nx;
  end

  // Pointers and occupancy; 3-bit pointers wrap 7 -> 0 naturally.
  always_ff @(posedge clk) begin
    if (flush) begin
      rd_ptr <= 3'd0;
      wr_ptr <= 3'd0;
      count  <= 4'd0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 3'd1;
      if (pop)     rd_ptr <= rd_ptr + 3'd1;
      case ({push_ok, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; data is masked to zero for non-writing instructions.
  always_ff @(posedge clk) begin
    if (!flush && push_ok) begin
      pc_mem[wr_ptr]    <= PcOut;
      instr_mem[wr_ptr] <= instruction;
      data_mem[wr_ptr]  <= RegWre ? WriteData : 32'h0;
      wb_mem[wr_ptr]    <= RegWre;
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk) begin
    if (flush) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (push_drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: doc/cpu_trace_buffer.md
CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have the following ports:
- clk  in  1  system clock, same clock as SingleCycleCPU.
- Reset  in  1  synchronous, active-high.
- enable  in  1  capture enable.
- clear  in  1  synchronous flush of FIFO, flags and state.
- PCWre  in  1  CPU commit strobe; one instruction retires per cycle with PCWre=1.
- PcOut  in  32  PC of the retiring instruction.
- instruction  in  32  retiring instruction word.
- RegWre  in  1  retiring instruction writes the register file.
- WriteData  in  32  register write-back value.
- rd_ready  in  1  consumer accepts the head entry.
- rd_valid  out  1  head entry is available.
- rd_pc  out  32  head entry PC.
- rd_instr  out  32  head entry instruction.
- rd_data  out  32  head entry data; 0 if RegWre was 0 at capture.
- rd_wb  out  1  head entry RegWre.
- count  out  4  entries held, range 0..8.
- overflow  out  1  sticky; at least one entry was dropped.
- drop_cnt  out  8  dropped entries, saturating at 255.
- halted  out  1  halt instruction captured.

Function
REQ-003 The buffer SHALL be an 8-entry FIFO of {pc, instr, data, wb}, using a 3-bit read pointer, a 3-bit write pointer and a 4-bit count.
REQ-004 The state machine SHALL have three states: IDLE, CAPTURE and HALTED.
REQ-005 State transitions:
- IDLE -> CAPTURE when enable=1.
- CAPTURE -> IDLE when enable=0.
- CAPTURE -> HALTED when the captured instruction equals 32'hFC000000.
- HALTED is left only by Reset or clear, which return the block to IDLE.
REQ-006 A push request SHALL occur when state=CAPTURE and PCWre=1 on a rising edge.
REQ-007 When a push request occurs, enable SHALL be sampled in the same cycle; enable falling on the same edge still suppresses the push.
REQ-008 A pop SHALL occur when rd_valid=1 and rd_ready=1.
REQ-009 rd_ready SHALL be ignored when rd_valid=0.
REQ-010 A push SHALL be accepted when count<8, or when count=8 and a pop occurs in the same cycle.
REQ-011 A push with count=8 and no pop SHALL be dropped.
REQ-012 A dropped push SHALL set overflow and SHALL increment drop_cnt, saturating at 255.
REQ-013 A simultaneous accepted push and pop SHALL leave count unchanged.
REQ-014 Both pointers SHALL wrap 7 -> 0.
REQ-015 Latency: an entry pushed at edge N SHALL appear at the head, if the FIFO was empty, with rd_valid=1 after edge N.
REQ-016 There SHALL be no combinational bypass from the capture inputs to the rd_* outputs.
REQ-017 rd_valid SHALL equal (count!=0).
REQ-018 rd_pc, rd_instr, rd_data and rd_wb SHALL show the entry at the read pointer.
REQ-019 rd_* outputs SHALL hold stable while rd_valid=1 and rd_ready=0.
REQ-020 rd_data SHALL store WriteData when RegWre=1, otherwise 32'h0.
REQ-021 A halt instruction SHALL itself be pushed under the normal full/drop rules; halted SHALL be set on the same edge.
REQ-022 In HALTED no pushes SHALL occur, while pops SHALL continue until the FIFO is empty.
REQ-023 clear SHALL have the same effect as Reset.
REQ-024 When clear and a push coincide, clear SHALL win and no entry is stored.

Reset
REQ-025 On Reset=1 at a rising edge the block SHALL set state=IDLE, both pointers 0, count=0, rd_valid=0, overflow=0, drop_cnt=0 and halted=0.
REQ-026 On Reset the rd_pc, rd_instr and rd_data outputs SHALL read 32'h0.
REQ-027 Reset during CAPTURE or HALTED SHALL discard all stored entries.
REQ-028 Reset SHALL take priority over clear, enable, PCWre and rd_ready.

Verification
REQ-029 Basic FIFO order: enable=1, three commits with PC 0x00, 0x04, 0x08, rd_ready=0 -> count=3, head rd_pc=0x00. Then rd_ready=1 for 3 cycles -> PCs 0x00, 0x04, 0x08 in order, rd_valid=0 afterwards.
REQ-030 Overflow: rd_ready=0, 10 commits -> count=8, overflow=1, drop_cnt=2; stored PCs are the first eight.
REQ-031 Full with simultaneous push and pop: count=8, PCWre=1 and rd_ready=1 in the same cycle -> count stays 8, drop_cnt unchanged, new PC stored at the tail.
REQ-032 Halt: commit of instruction 32'hFC000000 at PC 0x1C -> halted=1, that entry is stored, and later PCWre pulses add nothing; draining empties the FIFO with halted still 1.
REQ-033 Reset mid-operation: count=5 and overflow=1, Reset=1 for one edge -> count=0, rd_valid=0, overflow=0, drop_cnt=0, state=IDLE.
REQ-034 RegWre masking: commit with RegWre=0 and WriteData=0xDEADBEEF -> rd_data=0, rd_wb=0.
